// File: rtl/reset_sequencer.sv
// Staged reset sequencer: synchronizes async_in_rst release, holds all stages, then frees them in ascending order.
// Optional software reset is compiled in with `define RESET_SEQUENCER_SW_RST_EN.
module reset_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int N_OUT       = 3,
  parameter int STAGE_GAP   = 4
) (
  input  logic             clk,
  input  logic             async_in_rst,
  input  logic             sw_rst_req,
  output logic [N_OUT-1:0] stage_rst_n,
  output logic             rst_done,
  output logic             sw_rst_ack
);

  localparam int CNT_MAX = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    ST_RESET,
    ST_HOLD,
    ST_RELEASE,
    ST_RUN
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [N_OUT-1:0]       stage_q, stage_d;
  logic                   done_q, done_d;
  logic                   ack_q, ack_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_rst_n;
  logic                   sync_rise;
  logic                   sw_req;

  // Clears asynchronously; release only propagates through the flop chain.
  always_ff @(posedge clk or negedge async_in_rst) begin
    if (!async_in_rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sync_rst_n = sync_q[SYNC_STAGES-1];
  // Value sync_rst_n takes at this edge: RESET is left on the edge it rises.
  assign sync_rise  = sync_q[SYNC_STAGES-2] | sync_rst_n;

`ifdef RESET_SEQUENCER_SW_RST_EN
  assign sw_req = sw_rst_req;
`else
  logic unused_sw_rst_req;
  assign unused_sw_rst_req = sw_rst_req;
  assign sw_req            = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge async_in_rst) begin
    if (!async_in_rst) begin
      state_q <= ST_RESET;
      cnt_q   <= '0;
      stage_q <= '0;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    done_d  = 1'b0;
    ack_d   = 1'b0;
    unique case (state_q)
      ST_RESET: begin
        stage_d = '0;
        cnt_d   = '0;
        if (sync_rise) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
          stage_d = N_OUT'(1);
          cnt_d   = '0;
          state_d = ST_RELEASE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RELEASE: begin
        if (&stage_q) begin
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_RUN;
        end else if (cnt_q == CNT_W'(STAGE_GAP - 1)) begin
          // Shifting in a one keeps release order strictly ascending.
          stage_d = (stage_q << 1) | N_OUT'(1);
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        done_d = 1'b1;
        if (sw_req) begin
          stage_d = '0;
          done_d  = 1'b0;
          ack_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_RESET;
        stage_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  assign stage_rst_n = stage_q;
  assign rst_done    = done_q;
  assign sw_rst_ack  = ack_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: power-up, abort, ignored request, glitch, and software reset
// (software-reset checks follow RESET_SEQUENCER_SW_RST_EN).
`timescale 1ns/100ps
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       async_in_rst = 1'b0;
  logic       sw_rst_req = 1'b0;
  logic [2:0] stage_rst_n;
  logic       rst_done;
  logic       sw_rst_ack;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reset_sequencer #(
    .SYNC_STAGES(2),
    .HOLD_CYCLES(16),
    .N_OUT(3),
    .STAGE_GAP(4)
  ) dut (
    .clk(clk),
    .async_in_rst(async_in_rst),
    .sw_rst_req(sw_rst_req),
    .stage_rst_n(stage_rst_n),
    .rst_done(rst_done),
    .sw_rst_ack(sw_rst_ack)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [2:0] st, input logic done,
                               input logic ack);
    check({tag, ".stage"}, {5'd0, stage_rst_n}, {5'd0, st});
    check({tag, ".done"}, {7'd0, rst_done}, {7'd0, done});
    check({tag, ".ack"}, {7'd0, sw_rst_ack}, {7'd0, ack});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Edges first..last: stage k is high from edge base+4k, rst_done from base+9, never an ack.
  // sw_rst_req is driven high for edges sw_from..sw_to.
  task automatic run_seq(input int first, input int last, input int base,
                         input int sw_from, input int sw_to);
    logic [2:0] exp_st;
    for (int e = first; e <= last; e++) begin
      @(negedge clk);
      sw_rst_req = (e >= sw_from) && (e <= sw_to);
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) exp_st[k] = (e >= base + 4 * k);
      check_outputs($sformatf("edge%0d", e), exp_st, (e >= base + 9), 1'b0);
    end
    sw_rst_req = 1'b0;
  endtask

  // Called 1 ns after a rising edge; the next rising edge becomes edge 1.
  task automatic reassert_and_release(input string tag);
    async_in_rst = 1'b0;
    #1;
    check_outputs({tag, ".async"}, 3'b000, 1'b0, 1'b0);
    tick();
    check_outputs({tag, ".held"}, 3'b000, 1'b0, 1'b0);
    async_in_rst = 1'b1;
  endtask

  initial begin
    // Power-up: reset low for three cycles.
    repeat (3) tick();
    check_outputs("por", 3'b000, 1'b0, 1'b0);
    async_in_rst = 1'b1;
    run_seq(1, 30, 18, 0, -1);

    // Request during edges 10..20 is ignored; timing unchanged.
    reassert_and_release("ign");
    run_seq(1, 30, 18, 10, 20);

    // Abort between edges 23 and 24, then a full sequence.
    reassert_and_release("pre_abort");
    run_seq(1, 23, 18, 0, -1);
    #2;
    async_in_rst = 1'b0;
    #1;
    check_outputs("abort.async", 3'b000, 1'b0, 1'b0);
    tick();
    check_outputs("abort.held", 3'b000, 1'b0, 1'b0);
    async_in_rst = 1'b1;
    run_seq(1, 30, 18, 0, -1);

    // 1 ns glitch in RUN clears outputs without a clock and restarts the sequence.
    async_in_rst = 1'b0;
    #0.5;
    check_outputs("glitch", 3'b000, 1'b0, 1'b0);
    #0.5;
    async_in_rst = 1'b1;
    run_seq(1, 39, 18, 0, -1);

`ifdef RESET_SEQUENCER_SW_RST_EN
    // Software reset pulsed at edge 40.
    @(negedge clk);
    sw_rst_req = 1'b1;
    tick();
    check_outputs("sw.edge40", 3'b000, 1'b0, 1'b1);
    // Request high again from edge 60 through RUN entry at 65; ignored until then.
    run_seq(41, 65, 56, 60, 65);
    @(negedge clk);
    sw_rst_req = 1'b1;
    tick();
    check_outputs("sw.reentry66", 3'b000, 1'b0, 1'b1);
    run_seq(67, 95, 82, 0, -1);
`else
    // Without the feature, a held request in RUN does nothing.
    run_seq(40, 49, 18, 40, 49);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
